data_memory_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU in the single-cycle core.
//  - ALURes is the effective address; rs2 is the store data.
//  - Contains the word-organised data RAM and the byte/half/word lane logic.
//  - Adds a small MMIO block: GPIO, cycle counter, sticky misalignment fault capture.
//  - Read data goes to the write-back mux in the same cycle.

---
 rtl/dmu_pkg.sv | 66 ++++++
 rtl/dmu_mmio.sv | 86 ++++++++
 rtl/data_memory_unit.sv | 106 ++++++++++
 tb/tb_data_memory_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmu_pkg
// Brief    : Shared encodings, MMIO offsets and load lane helpers for the
//            data memory unit.
// Revision : 1.0 - initial release
// ============================================================================
package dmu_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    localparam logic [7:0] OFF_GPIO   = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_FADDR  = 8'h0C;

    function automatic logic ctrl_valid(input logic [2:0] ctrl);
        return (ctrl == DM_B) || (ctrl == DM_H) || (ctrl == DM_W) ||
               (ctrl == DM_BU) || (ctrl == DM_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] ctrl,
                                           input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (ctrl)
            DM_H, DM_HU: r = lo[0];
            DM_W:        r = (lo != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half out of a word and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  ctrl,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (ctrl)
            DM_B:    r = {{24{b[7]}}, b};
            DM_BU:   r = {24'd0, b};
            DM_H:    r = {{16{h[15]}}, h};
            DM_HU:   r = {16'd0, h};
            DM_W:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmu_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmu_mmio
// Brief    : MMIO register block: GPIO, optional cycle counter (macro
//            DMU_CYCLE_CNT_EN), sticky misalignment fault and read mux.
// Revision : 1.0 - initial release
// ============================================================================
module dmu_mmio
    import dmu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wr,
    input  logic [7:0]  offset,
    input  logic [7:0]  wdata,
    input  logic        fault_set,
    input  logic [31:0] fault_addr_in,
    output logic [31:0] rdata,
    output logic [7:0]  gpio,
    output logic        fault,
    output logic [31:0] faddr
);

    logic [7:0]  r_gpio;
    logic        r_fault;
    logic [31:0] r_faddr;
    logic        w_wr_en;

    assign w_wr_en = sel && wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio  <= 8'd0;
            r_fault <= 1'b0;
            r_faddr <= 32'd0;
        end else begin
            if (w_wr_en && offset == OFF_GPIO) begin
                r_gpio <= wdata;
            end
            // Only the first fault since the last clear records its address.
            if (fault_set) begin
                r_fault <= 1'b1;
                if (!r_fault) begin
                    r_faddr <= fault_addr_in;
                end
            end else if (w_wr_en && offset == OFF_STATUS && wdata[0]) begin
                r_fault <= 1'b0;
                r_faddr <= 32'd0;
            end
        end
    end

`ifdef DMU_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (offset)
                OFF_GPIO:   rdata = {24'd0, r_gpio};
`ifdef DMU_CYCLE_CNT_EN
                OFF_CYCLE:  rdata = r_cycle;
`endif
                OFF_STATUS: rdata = {31'd0, r_fault};
                OFF_FADDR:  rdata = r_faddr;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign gpio  = r_gpio;
    assign fault = r_fault;
    assign faddr = r_faddr;

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_unit
// Brief    : Load/store stage: word RAM with byte lanes, address decode,
//            alignment check and MMIO block (cycle counter: DMU_CYCLE_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_unit
    import dmu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic [7:0]  GpioOut,
    output logic        MisalignFault,
    output logic [31:0] FaultAddr
);

    localparam int c_AW = $clog2(DEPTH_WORDS) + 2;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_valid;
    logic            w_misalign;
    logic            w_in_ram;
    logic            w_in_mmio;
    logic            w_mmio_sel;
    logic            w_ram_we;
    logic [c_AW-3:0] w_idx;
    logic [31:0]     w_ram_word;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_mmio_rdata;

    assign w_valid    = ctrl_valid(DMCtrl);
    assign w_misalign = is_misaligned(DMCtrl, Address[1:0]);
    assign w_in_ram   = (Address[31:c_AW] == '0);
    assign w_in_mmio  = (Address[31:8] == MMIO_BASE[31:8]);
    assign w_mmio_sel = w_in_mmio && (DMCtrl == DM_W) && !w_misalign;
    assign w_idx      = Address[c_AW-1:2];
    assign w_ram_word = r_mem[w_idx];
    assign w_ram_we   = DMWr && !rst && w_in_ram && w_valid && !w_misalign;

    // Store data is replicated across lanes so the enables alone pick bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = DataWr;
        case (DMCtrl)
            DM_B, DM_BU: begin
                w_be    = 4'b0001 << Address[1:0];
                w_wdata = {4{DataWr[7:0]}};
            end
            DM_H, DM_HU: begin
                w_be    = Address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{DataWr[15:0]}};
            end
            DM_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        DataRd = 32'd0;
        if (!w_misalign) begin
            if (w_in_ram && w_valid) begin
                DataRd = lane_extract(w_ram_word, DMCtrl, Address[1:0]);
            end else if (w_mmio_sel) begin
                DataRd = w_mmio_rdata;
            end
        end
    end

    dmu_mmio u_mmio (
        .clk           (clk),
        .rst           (rst),
        .sel           (w_mmio_sel),
        .wr            (DMWr),
        .offset        (Address[7:0]),
        .wdata         (DataWr[7:0]),
        .fault_set     (w_misalign),
        .fault_addr_in (Address),
        .rdata         (w_mmio_rdata),
        .gpio          (GpioOut),
        .fault         (MisalignFault),
        .faddr         (FaultAddr)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_unit
// Brief    : Directed, table-driven self-checking bench for data_memory_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_unit;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic [7:0]  GpioOut;
    logic        MisalignFault;
    logic [31:0] FaultAddr;

    int checks   = 0;
    int failures = 0;

    data_memory_unit u_dut (
        .clk           (clk),
        .rst           (rst),
        .Address       (Address),
        .DataWr        (DataWr),
        .DMWr          (DMWr),
        .DMCtrl        (DMCtrl),
        .DataRd        (DataRd),
        .GpioOut       (GpioOut),
        .MisalignFault (MisalignFault),
        .FaultAddr     (FaultAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] rd;
        logic [7:0]  gpio;
        logic        fault;
        logic [31:0] faddr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    function automatic vec_t mk(logic wr, logic [2:0] ctrl, logic [31:0] addr,
                                logic [31:0] wdata, logic chk_rd, logic [31:0] rd,
                                logic [7:0] gpio, logic fault, logic [31:0] faddr);
        vec_t v;
        v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.rd = rd; v.gpio = gpio; v.fault = fault; v.faddr = faddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        DMWr = wr; DMCtrl = ctrl; Address = addr; DataWr = wdata;
    endtask

    initial begin
        // wr ctrl addr wdata chk rd | state before edge: gpio fault faddr
        vecs.push_back(mk(1, W,  32'h100, 32'h11223344, 0, 32'h0, 8'h00, 0, 32'h0));
        vecs.push_back(mk(1, B,  32'h101, 32'h000000AB, 1, 32'h00000033, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h100, 32'h0, 1, 32'h1122AB44, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, B,  32'h101, 32'h0, 1, 32'hFFFFFFAB, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, BU, 32'h101, 32'h0, 1, 32'h000000AB, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, H,  32'h102, 32'h0, 1, 32'h00001122, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, H,  32'h100, 32'h0, 1, 32'hFFFFAB44, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, HU, 32'h100, 32'h0, 1, 32'h0000AB44, 8'h00, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'h102, 32'hDEADBEEF, 1, 32'h0, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h100, 32'h0, 1, 32'h1122AB44, 8'h00, 1, 32'h102));
        vecs.push_back(mk(0, H,  32'h203, 32'h0, 1, 32'h0, 8'h00, 1, 32'h102));
        vecs.push_back(mk(0, W,  32'hFFFF0008, 32'h0, 1, 32'h1, 8'h00, 1, 32'h102));
        vecs.push_back(mk(0, W,  32'hFFFF000C, 32'h0, 1, 32'h102, 8'h00, 1, 32'h102));
        vecs.push_back(mk(1, W,  32'hFFFF0008, 32'h1, 1, 32'h1, 8'h00, 1, 32'h102));
        vecs.push_back(mk(0, W,  32'hFFFF0008, 32'h0, 1, 32'h0, 8'h00, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'hFFFF0000, 32'h1A5, 1, 32'h0, 8'h00, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFFF0000, 32'h0, 1, 32'hA5, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, B,  32'hFFFF0000, 32'h5A, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFFF0000, 32'h0, 1, 32'hA5, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'h80000000, 32'h12345678, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h80000000, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, 3'b110, 32'h100, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h100, 32'h0, 1, 32'h1122AB44, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, H,  32'h102, 32'hCAFEBEEF, 1, 32'h00001122, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h100, 32'h0, 1, 32'hBEEFAB44, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'hFFC, 32'h55AA55AA, 0, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFC, 32'h0, 1, 32'h55AA55AA, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'h1000, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'h1000, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'hFFFF000C, 32'h5, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFFF0010, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'hFFFF0008, 32'hFFFFFFFE, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFFF0002, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, HU, 32'h105, 32'h0, 1, 32'h0, 8'hA5, 1, 32'hFFFF0002));
        vecs.push_back(mk(1, W,  32'hFFFF0008, 32'hFFFFFFFF, 1, 32'h1, 8'hA5, 1, 32'hFFFF0002));
        vecs.push_back(mk(0, W,  32'hFFFF0008, 32'h0, 1, 32'h0, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(1, W,  32'hFFFF0000, 32'h0, 1, 32'hA5, 8'hA5, 0, 32'h0));
        vecs.push_back(mk(0, W,  32'hFFFF0000, 32'h0, 1, 32'h0, 8'h00, 0, 32'h0));

        // Reset, with a GPIO store held during reset that must be dropped.
        rst = 1'b1;
        drive(1, W, 32'hFFFF0000, 32'hFF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio", {24'd0, GpioOut}, 32'h0);
        chk("rst_fault", {31'd0, MisalignFault}, 32'h0);
        chk("rst_faddr", FaultAddr, 32'h0);
        rst = 1'b0;
        drive(0, W, 32'hFFFF0004, 32'h0);
        #1;
        chk("cycle_first", DataRd, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_store_dropped", {24'd0, GpioOut}, 32'h0);
`ifdef DMU_CYCLE_CNT_EN
        chk("cycle_second", DataRd, 32'h1);
`else
        chk("cycle_absent", DataRd, 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata);
            #1;
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), DataRd, vecs[i].rd);
            chk($sformatf("v%0d_gpio", i), {24'd0, GpioOut}, {24'd0, vecs[i].gpio});
            chk($sformatf("v%0d_fault", i), {31'd0, MisalignFault}, {31'd0, vecs[i].fault});
            chk($sformatf("v%0d_faddr", i), FaultAddr, vecs[i].faddr);
            @(posedge clk);
            #1;
        end

`ifdef DMU_CYCLE_CNT_EN
        // Counter wrap: preload near the top and watch it roll over.
        drive(0, W, 32'hFFFF0004, 32'h0);
        force u_dut.u_mmio.r_cycle = 32'hFFFFFFFE;
        #1;
        release u_dut.u_mmio.r_cycle;
        @(posedge clk);
        #1;
        chk("cycle_wrap_max", DataRd, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        chk("cycle_wrap_zero", DataRd, 32'h0);
`endif

        // Mid-run reset clears GPIO and a pending fault; set up both first.
        drive(1, W, 32'hFFFF0000, 32'h3C);
        @(posedge clk);
        #1;
        drive(0, W, 32'h1, 32'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_gpio", {24'd0, GpioOut}, 32'h3C);
        chk("pre_rst_fault", {31'd0, MisalignFault}, 32'h1);
        chk("pre_rst_faddr", FaultAddr, 32'h1);
        rst = 1'b1;
        drive(0, W, 32'h3, 32'h0);
        @(posedge clk);
        #1;
        chk("rst2_gpio", {24'd0, GpioOut}, 32'h0);
        chk("rst2_fault", {31'd0, MisalignFault}, 32'h0);
        chk("rst2_faddr", FaultAddr, 32'h0);
        rst = 1'b0;
        drive(0, W, 32'h100, 32'h0);
        #1;
        chk("ram_kept_over_rst", DataRd, 32'hBEEFAB44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
